// File: rtl/rose_resp_pkg.sv
// Shared types, delay limits and the delay clamp for the rose-window responder.
package rose_resp_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST,
    S_GAP
  } resp_state_e;

  localparam logic [2:0] MIN_DLY = 3'd1;
  localparam logic [2:0] MAX_DLY = 3'd5;

  function automatic logic [2:0] clamp_dly(input logic [2:0] d);
    if (d < MIN_DLY) return MIN_DLY;
    if (d > MAX_DLY) return MAX_DLY;
    return d;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-cycle edge detector; POL=1 flags rising edges, POL=0 flags falling edges.
module rise_detect #(
  parameter logic POL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic hit
);

  logic sig_q;
  logic sig_d;

  assign sig_d = sig;

  // Reset to the active level so a line already at that level is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= POL;
    else     sig_q <= sig_d;
  end

  assign hit = POL ? (sig & ~sig_q) : (~sig & sig_q);

endmodule

// File: rtl/rose_window_responder.sv
// Responder: after a request edge on a, waits a clamped 1..5 cycle delay, drives a
// BURST_LEN-cycle b burst, then one mandatory low gap cycle. Overlapping requests are dropped.
module rose_window_responder
  import rose_resp_pkg::*;
#(
  parameter int BURST_LEN = 3,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a,
  input  logic [2:0]       dly_cfg,
  output logic             b,
  output logic             busy,
  output logic             drop,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int BC_W = $clog2(BURST_LEN + 1);
  localparam logic [BC_W-1:0] BURST_INIT = BC_W'(BURST_LEN);
  localparam logic [BC_W-1:0] BURST_LAST = BC_W'(1);

  logic             rise;
  logic             req;
  logic [2:0]       dly_c;

  resp_state_e      state_q, state_d;
  logic [2:0]       dcnt_q, dcnt_d;
  logic [BC_W-1:0]  bcnt_q, bcnt_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  rise_detect #(.POL(1'b1)) u_rise (
    .clk (clk),
    .rst (rst),
    .sig (a),
    .hit (rise)
  );

  assign req   = rise & en;
  assign dly_c = clamp_dly(dly_cfg);

  always_comb begin
    state_d    = state_q;
    dcnt_d     = dcnt_q;
    bcnt_d     = bcnt_q;
    drop_cnt_d = drop_cnt_q;

    // Any accepted-looking request outside IDLE is discarded, never queued.
    drop_d = req && (state_q != S_IDLE);
    if (drop_d && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (dly_c == MIN_DLY) begin
            state_d = S_BURST;
            bcnt_d  = BURST_INIT;
          end else begin
            state_d = S_WAIT;
            dcnt_d  = dly_c - 3'd1;
          end
        end
      end
      S_WAIT: begin
        if (dcnt_q == 3'd1) begin
          state_d = S_BURST;
          bcnt_d  = BURST_INIT;
        end else begin
          dcnt_d = dcnt_q - 3'd1;
        end
      end
      S_BURST: begin
        if (bcnt_q == BURST_LAST) state_d = S_GAP;
        else                      bcnt_d  = bcnt_q - BURST_LAST;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs follow the next state so they are registered alongside it.
    b_d    = (state_d == S_BURST);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dcnt_q     <= '0;
      bcnt_q     <= '0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      bcnt_q     <= bcnt_d;
      b_q        <= b_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign b        = b_q;
  assign busy     = busy_q;
  assign drop     = drop_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: doc/rose_window_responder.md
# rose_window_responder

Responder side of the request/response handshake whose monitor property is "rising `a` implies `b` within 1 to 5 cycles, and a `b` burst of `BURST_LEN` cycles is followed by `!b`".
- Detects rising edges of request `a` and waits a configurable delay, clamped to 1..5 cycles.
- Then drives `b` high for exactly `BURST_LEN` consecutive cycles, followed by at least one mandatory low cycle.
- Sits opposite the assertion-checked initiator; used both as bench stimulus and as a synthesizable responder.

## Interface
Parameters:
- BURST_LEN, 3, number of consecutive cycles `b` is held high (≥1)
- CNT_W, 8, width of the dropped-request counter

Ports:
- clk  input  1  single clock; all state updates on posedge clk
- rst  input  1  asynchronous, active-high reset
- en  input  1  when 0, new rising edges are ignored and not counted as drops
- a  input  1  request line; a rising edge is a request
- dly_cfg  input  3  response delay in cycles, sampled on the request cycle
- b  output  1  response, registered
- busy  output  1  high in any state other than IDLE, registered
- drop  output  1  one-cycle pulse when a request arrives while busy, registered
- drop_cnt  output  CNT_W  saturating count of dropped requests

## Operation
- Rise detect: `rise = a & ~a_q`, where `a_q` is `a` registered.
  - `a_q` resets to 1, so `a` held high through reset deassertion is not a request.
- Delay clamp, applied on the request cycle: 0 becomes 1; 6 and 7 become 5; 1..5 are used unchanged. The clamped value D is latched.
- FSM states: IDLE, WAIT, BURST, GAP.
- IDLE, on `rise & en`:
  - D = 1: go directly to BURST.
  - D > 1: go to WAIT with `dcnt = D-1`.
- WAIT: decrement `dcnt` each cycle; go to BURST when it reaches 1.
- BURST: `b` = 1; count `BURST_LEN` cycles, then go to GAP.
- GAP: `b` = 0 for exactly one cycle, then go to IDLE.
  - A rise seen during GAP is dropped.
  - Guarantees `b[*BURST_LEN] |=> !b`.
- Drops: `rise & en` in WAIT, BURST or GAP:
  - `drop` pulses for one cycle.
  - `drop_cnt` increments and saturates at all-ones. It never wraps.
  - The FSM is unaffected and requests are not queued.
- `en` deasserted mid-response: the current response completes normally.
- `dly_cfg` changes after the request cycle have no effect on the response in flight.

## Timing
- Request cycle t: the first cycle where `a` = 1 sampled after `a` = 0.
- `b` rises at cycle t+D and stays high through cycle t+D+BURST_LEN-1.
- `b` is low at t+D+BURST_LEN (GAP).
- The earliest new accepted request is the cycle after GAP, i.e. t+D+BURST_LEN+1.
- `busy` is high from t+1 through the GAP cycle inclusive.
- `drop` is asserted in the cycle after the offending rise cycle.
- Reset values: `b`=0, `busy`=0, `drop`=0, `drop_cnt`=0, state=IDLE, `a_q`=1.
- Reset mid-response: outputs clear immediately (asynchronous). No residual burst after release.
- All outputs are registered; there is no combinational path from `a` to any output.

## Structure
- Package `rose_resp_pkg`, containing:
  - the state enum `resp_state_e`
  - constants `MIN_DLY`=1 and `MAX_DLY`=5
  - the clamp function `clamp_dly(logic [2:0]) -> logic [2:0]`
- Sub-module `rise_detect`: holds the `a_q` register with reset value 1 and outputs `rise`. It is reusable for `$fell`-style detection via a polarity parameter.
- Top level holds the FSM, `dcnt`, the burst counter (width $clog2(BURST_LEN+1)) and the drop counter.

## Test plan
- `dly_cfg`=3, single rise of `a` at cycle 10 -> `b`=1 on cycles 13,14,15; `b`=0 on 16; `busy` high 11..16.
- `dly_cfg`=0 and `dly_cfg`=7, one rise each, spaced apart -> `b` first rises 1 cycle and 5 cycles after the rise respectively.
- Second rise of `a` during BURST -> `drop` pulses once, `drop_cnt`=1, first burst unchanged at 3 cycles.
- `a` high through reset release -> no `b` activity until `a` falls and rises again.
- `rst` asserted during BURST -> `b`, `busy` go 0 without waiting for a clock edge; a fresh request afterwards gives a full normal response.
- CNT_W=2, five drops -> `drop_cnt` reads 1,2,3,3,3; `en`=0 with a rise in IDLE -> no response and no drop.
